// File: rtl/obf_ctrl_pkg.sv
// Shared types and defaults for the obfuscation key load controller.
// The key FSM encoding, reset key value and fail-counter sizing live here.
package obf_ctrl_pkg;

  localparam int unsigned KEY_W_DEF    = 2;
  localparam int unsigned CHUNK_W_DEF  = 1;
  localparam int unsigned MAX_FAIL_DEF = 3;
  localparam int unsigned DIN_W_DEF    = 41;
  localparam int unsigned DOUT_W_DEF   = 32;

  localparam logic [KEY_W_DEF-1:0] KEY_DEFAULT = '0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_LOCKOUT = 3'd4
  } key_state_e;

  // Width of a counter that must be able to hold max_val itself.
  function automatic int unsigned fail_cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/obf_key_shreg.sv
// Shadow key shift register: LSB-first chunk assembly, beat counting,
// parity latch on the final beat and combinational parity compare.
module obf_key_shreg #(
  parameter int unsigned KEY_W   = 2,
  parameter int unsigned CHUNK_W = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               shift,
  input  logic [CHUNK_W-1:0] kin_data,
  input  logic               kin_parity,
  output logic [KEY_W-1:0]   shadow,
  output logic               last_beat_c,
  output logic               parity_ok_c
);

  localparam int unsigned BEATS = KEY_W / CHUNK_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CNT_W-1:0] beat_q;
  logic             parity_q;
  logic [KEY_W-1:0] shadow_nxt;

  // New chunk enters at the top so the first beat ends up in the LSBs.
  generate
    if (KEY_W == CHUNK_W) begin : g_single
      assign shadow_nxt = kin_data;
    end else begin : g_multi
      assign shadow_nxt = {kin_data, shadow[KEY_W-1:CHUNK_W]};
    end
  endgenerate

  assign last_beat_c = (beat_q == CNT_W'(BEATS - 1));
  assign parity_ok_c = ((^shadow) == parity_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow   <= '0;
      beat_q   <= '0;
      parity_q <= 1'b0;
    end else if (clear) begin
      shadow <= '0;
      beat_q <= '0;
    end else if (shift) begin
      shadow <= shadow_nxt;
      beat_q <= last_beat_c ? '0 : beat_q + CNT_W'(1);
      if (last_beat_c) parity_q <= kin_parity;
    end
  end

endmodule

// File: rtl/obf_key_load_ctrl.sv
// Key load sequencer for a key-locked combinational core: serial key load,
// parity check, atomic commit, failure lockout and a 2-stage query pipeline.
module obf_key_load_ctrl
  import obf_ctrl_pkg::*;
#(
  parameter int unsigned      KEY_W       = KEY_W_DEF,
  parameter int unsigned      CHUNK_W     = CHUNK_W_DEF,
  parameter int unsigned      MAX_FAIL    = MAX_FAIL_DEF,
  parameter int unsigned      DIN_W       = DIN_W_DEF,
  parameter int unsigned      DOUT_W      = DOUT_W_DEF,
  parameter logic [KEY_W-1:0] KEY_DEFAULT = KEY_W'(obf_ctrl_pkg::KEY_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start,
  input  logic               load_abort,
  input  logic               kin_valid,
  output logic               kin_ready,
  input  logic [CHUNK_W-1:0] kin_data,
  input  logic               kin_parity,
  output logic [KEY_W-1:0]   key_out,
  output logic               key_valid,
  output logic               load_done,
  output logic               load_err,
  output logic               locked_out,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [DIN_W-1:0]   req_data,
  output logic [DIN_W-1:0]   core_in,
  input  logic [DOUT_W-1:0]  core_out,
  output logic               resp_valid,
  output logic [DOUT_W-1:0]  resp_data
);

  localparam int unsigned FAIL_W = fail_cnt_w(MAX_FAIL);

  key_state_e       state_q, state_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic [KEY_W-1:0] key_d;
  logic             key_valid_d;
  logic             done_d, err_d;
  logic             sh_clear, sh_shift;
  logic [KEY_W-1:0] shadow;
  logic             last_beat_c, parity_ok_c;
  logic             flush, req_accept, stage_v;

  obf_key_shreg #(
    .KEY_W   (KEY_W),
    .CHUNK_W (CHUNK_W)
  ) u_shreg (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (sh_clear),
    .shift       (sh_shift),
    .kin_data    (kin_data),
    .kin_parity  (kin_parity),
    .shadow      (shadow),
    .last_beat_c (last_beat_c),
    .parity_ok_c (parity_ok_c)
  );

  // Next-state and registered-output decode; abort beats a same-cycle final beat.
  always_comb begin
    state_d     = state_q;
    fail_d      = fail_q;
    key_d       = key_out;
    key_valid_d = key_valid;
    done_d      = 1'b0;
    err_d       = 1'b0;
    sh_clear    = 1'b0;
    sh_shift    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d  = ST_SHIFT;
          sh_clear = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (load_abort) begin
          state_d  = ST_IDLE;
          sh_clear = 1'b1;
        end else if (kin_valid) begin
          sh_shift = 1'b1;
          if (last_beat_c) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (load_abort) begin
          state_d  = ST_IDLE;
          sh_clear = 1'b1;
        end else if (parity_ok_c) begin
          state_d = ST_COMMIT;
        end else begin
          err_d = 1'b1;
          if (fail_q == FAIL_W'(MAX_FAIL - 1)) begin
            state_d     = ST_LOCKOUT;
            fail_d      = FAIL_W'(MAX_FAIL);
            key_d       = KEY_DEFAULT;
            key_valid_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
            fail_d  = fail_q + FAIL_W'(1);
          end
        end
      end
      ST_COMMIT: begin
        state_d     = ST_IDLE;
        key_d       = shadow;
        key_valid_d = 1'b1;
        done_d      = 1'b1;
        fail_d      = '0;
      end
      ST_LOCKOUT: begin
        key_d       = KEY_DEFAULT;
        key_valid_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fail_q     <= '0;
      key_out    <= KEY_DEFAULT;
      key_valid  <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      locked_out <= 1'b0;
      kin_ready  <= 1'b0;
      req_ready  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fail_q     <= fail_d;
      key_out    <= key_d;
      key_valid  <= key_valid_d;
      load_done  <= done_d;
      load_err   <= err_d;
      locked_out <= (state_d == ST_LOCKOUT);
      kin_ready  <= (state_d == ST_SHIFT);
      req_ready  <= key_valid_d && (state_d != ST_LOCKOUT);
    end
  end

  // Query pipeline; key_out and core_in move on the same edge, so every
  // response is computed under exactly one key.
  assign req_accept = req_valid && req_ready;
  assign flush      = (state_d == ST_LOCKOUT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_v    <= 1'b0;
      core_in    <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      stage_v    <= req_accept && !flush;
      resp_valid <= stage_v && !flush;
      if (req_accept) core_in <= req_data;
      if (flush || !key_valid) begin
        resp_data <= '0;
      end else if (stage_v) begin
        resp_data <= core_out;
      end
    end
  end

endmodule

// File: tb/tb_obf_key_load_ctrl.sv
// Directed bench for obf_key_load_ctrl with a behavioural key-dependent core.
module tb_obf_key_load_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic        load_abort;
  logic        kin_valid;
  logic        kin_ready;
  logic [0:0]  kin_data;
  logic        kin_parity;
  logic [1:0]  key_out;
  logic        key_valid;
  logic        load_done;
  logic        load_err;
  logic        locked_out;
  logic        req_valid;
  logic        req_ready;
  logic [40:0] req_data;
  logic [40:0] core_in;
  logic [31:0] core_out;
  logic        resp_valid;
  logic [31:0] resp_data;

  int n_tests;
  int n_fail;

  obf_key_load_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_abort (load_abort),
    .kin_valid  (kin_valid),
    .kin_ready  (kin_ready),
    .kin_data   (kin_data),
    .kin_parity (kin_parity),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .load_done  (load_done),
    .load_err   (load_err),
    .locked_out (locked_out),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .core_in    (core_in),
    .core_out   (core_out),
    .resp_valid (resp_valid),
    .resp_data  (resp_data)
  );

  // Stand-in for the locked core: output depends on both data and key.
  function automatic logic [31:0] core_model(input logic [40:0] d, input logic [1:0] k);
    return d[31:0] ^ {23'd0, d[40:32]} ^ {16{k}};
  endfunction

  assign core_out = core_model(core_in, key_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_key_out"},    64'(key_out),    64'(0));
    chk({tag, "_key_valid"},  64'(key_valid),  64'(0));
    chk({tag, "_kin_ready"},  64'(kin_ready),  64'(0));
    chk({tag, "_req_ready"},  64'(req_ready),  64'(0));
    chk({tag, "_locked"},     64'(locked_out), 64'(0));
    chk({tag, "_load_done"},  64'(load_done),  64'(0));
    chk({tag, "_load_err"},   64'(load_err),   64'(0));
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
    chk({tag, "_resp_data"},  64'(resp_data),  64'(0));
    chk({tag, "_core_in"},    64'(core_in),    64'(0));
  endtask

  // Start a load and present both beats; returns with the DUT in CHECK (or IDLE if aborted).
  task automatic load_seq(input logic [1:0] k, input logic par, input logic abort_final);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    kin_valid  = 1'b1;
    kin_data   = k[0];
    tick();
    kin_data   = k[1];
    kin_parity = par;
    load_abort = abort_final;
    tick();
    kin_valid  = 1'b0;
    load_abort = 1'b0;
  endtask

  logic [40:0] qd [10];
  logic [40:0] qa;
  logic [1:0]  exp_key;

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    load_start = 1'b0;
    load_abort = 1'b0;
    kin_valid  = 1'b0;
    kin_data   = 1'b0;
    kin_parity = 1'b0;
    req_valid  = 1'b0;
    req_data   = '0;
    for (int i = 0; i < 10; i++) qd[i] = {9'(i + 3), 32'hC0DE_0000 | 32'(i * 17)};

    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Load key 2'b10: beats 0 then 1, parity 1
    load_seq(2'b10, 1'b1, 1'b0);
    chk("t1_kin_ready_check", 64'(kin_ready), 64'(0));
    tick();
    chk("t1_done_in_commit",  64'(load_done), 64'(0));
    chk("t1_valid_in_commit", 64'(key_valid), 64'(0));
    tick();
    chk("t1_load_done", 64'(load_done), 64'(1));
    chk("t1_key_out",   64'(key_out),   64'(2'b10));
    chk("t1_key_valid", 64'(key_valid), 64'(1));
    chk("t1_req_ready", 64'(req_ready), 64'(1));
    tick();
    chk("t1_done_pulse", 64'(load_done), 64'(0));

    // Single query, latency 2
    qa = 41'h1_2345_6789;
    req_valid = 1'b1;
    req_data  = qa;
    tick();
    req_valid = 1'b0;
    chk("t2_core_in",   64'(core_in),    64'(qa));
    chk("t2_rv_early",  64'(resp_valid), 64'(0));
    tick();
    chk("t2_rv",        64'(resp_valid), 64'(1));
    chk("t2_rd",        64'(resp_data),  64'(32'h2345_6789 ^ 32'h1 ^ 32'hAAAA_AAAA));
    tick();
    chk("t2_rv_after",  64'(resp_valid), 64'(0));

    // Four back-to-back queries
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_data  = qd[i];
      tick();
      if (i > 0) begin
        chk("t2_b2b_rv", 64'(resp_valid), 64'(1));
        chk("t2_b2b_rd", 64'(resp_data),  64'(core_model(qd[i-1], 2'b10)));
      end
    end
    req_valid = 1'b0;
    tick();
    chk("t2_b2b_rv_last", 64'(resp_valid), 64'(1));
    chk("t2_b2b_rd_last", 64'(resp_data),  64'(core_model(qd[3], 2'b10)));
    tick();
    chk("t2_b2b_idle", 64'(resp_valid), 64'(0));

    // Abort on final beat keeps the committed key
    load_seq(2'b01, 1'b1, 1'b1);
    chk("t4_kin_ready", 64'(kin_ready), 64'(0));
    tick();
    chk("t4_no_err", 64'(load_err), 64'(0));
    tick();
    chk("t4_no_done",  64'(load_done), 64'(0));
    chk("t4_key_kept", 64'(key_out),   64'(2'b10));
    chk("t4_valid",    64'(key_valid), 64'(1));

    // Reload 2'b01 while streaming; key switches at the edge that ends COMMIT
    for (int c = 0; c < 10; c++) begin
      req_valid  = 1'b1;
      req_data   = qd[c];
      load_start = (c == 0);
      kin_valid  = (c == 1) || (c == 2);
      kin_data   = (c == 1) ? 1'b1 : 1'b0;
      kin_parity = 1'b1;
      tick();
      if (c > 0) begin
        exp_key = (c - 1 >= 4) ? 2'b01 : 2'b10;
        chk("t5_rv", 64'(resp_valid), 64'(1));
        chk("t5_rd", 64'(resp_data),  64'(core_model(qd[c-1], exp_key)));
      end
      if (c == 3) chk("t5_key_old", 64'(key_out), 64'(2'b10));
      if (c == 4) begin
        chk("t5_done",    64'(load_done), 64'(1));
        chk("t5_key_new", 64'(key_out),   64'(2'b01));
      end
    end
    req_valid  = 1'b0;
    load_start = 1'b0;
    kin_valid  = 1'b0;
    tick();
    chk("t5_rd_last", 64'(resp_data), 64'(core_model(qd[9], 2'b01)));
    tick();

    // Parity failures: fail, abort, fail, fail -> lockout on the third failure
    load_seq(2'b01, 1'b0, 1'b0);
    tick();
    chk("t3_err1",    64'(load_err),   64'(1));
    chk("t3_lock1",   64'(locked_out), 64'(0));
    chk("t3_key1",    64'(key_out),    64'(2'b01));
    chk("t3_valid1",  64'(key_valid),  64'(1));
    load_seq(2'b01, 1'b0, 1'b1);
    tick();
    chk("t3_abort_no_err", 64'(load_err), 64'(0));
    load_seq(2'b01, 1'b0, 1'b0);
    tick();
    chk("t3_err2",  64'(load_err),   64'(1));
    chk("t3_lock2", 64'(locked_out), 64'(0));

    // Third failure with a query in flight and one offered in CHECK
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    kin_valid  = 1'b1;
    kin_data   = 1'b1;
    tick();
    kin_data   = 1'b0;
    kin_parity = 1'b0;
    req_valid  = 1'b1;
    req_data   = qd[5];
    tick();
    kin_valid  = 1'b0;
    req_data   = qd[6];
    tick();
    req_valid  = 1'b0;
    chk("t3_err3",       64'(load_err),   64'(1));
    chk("t3_locked",     64'(locked_out), 64'(1));
    chk("t3_key_zero",   64'(key_out),    64'(0));
    chk("t3_key_valid",  64'(key_valid),  64'(0));
    chk("t3_req_ready",  64'(req_ready),  64'(0));
    chk("t3_kin_ready",  64'(kin_ready),  64'(0));
    chk("t3_flush_rv",   64'(resp_valid), 64'(0));
    chk("t3_flush_rd",   64'(resp_data),  64'(0));
    tick();
    chk("t3_err_pulse",  64'(load_err),   64'(0));
    chk("t3_flush_rv2",  64'(resp_valid), 64'(0));
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    tick();
    chk("t3_start_ignored", 64'(kin_ready),  64'(0));
    chk("t3_still_locked",  64'(locked_out), 64'(1));

    // Reset out of lockout, reload, then reset mid-SHIFT with queries in flight
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_all_zero("t6_unlock");
    load_seq(2'b10, 1'b1, 1'b0);
    tick();
    tick();
    chk("t6_key_valid", 64'(key_valid), 64'(1));
    chk("t6_key_out",   64'(key_out),   64'(2'b10));
    req_valid  = 1'b1;
    req_data   = qd[7];
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    kin_valid  = 1'b1;
    kin_data   = 1'b0;
    req_data   = qd[8];
    tick();
    chk("t6_inflight_rv", 64'(resp_valid), 64'(1));
    chk("t6_in_shift",    64'(kin_ready),  64'(1));
    rst_n     = 1'b0;
    req_valid = 1'b0;
    kin_valid = 1'b0;
    tick();
    chk_all_zero("t6_reset");
    rst_n      = 1'b1;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("t6_idle_after_reset", 64'(kin_ready), 64'(1));
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
    chk("t6_abort_idle", 64'(kin_ready), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
